// File: rtl/bsearch_ctrl.sv
// Sequencing controller for a binary search over a sorted 2^ADDR_W-entry memory.
// Issues probe addresses, waits out the datapath latency and narrows [lo, hi] from the compare flags.
module bsearch_ctrl #(
  parameter int ADDR_W = 5,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              found_in,
  input  logic              greater_in,
  output logic [ADDR_W-1:0] search_addr,
  output logic              busy,
  output logic              done,
  output logic              hit,
  output logic [ADDR_W-1:0] result_addr,
  output logic [3:0]        probes
);

  localparam int WCW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [ADDR_W:0]   ONE      = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   TOP      = (ADDR_W+1)'((1 << ADDR_W) - 1);
  localparam logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}};

  typedef enum logic [2:0] {IDLE, PROBE, WAIT, EVAL, DONE} state_t;

  state_t          state;
  logic [ADDR_W:0] lo;
  logic [ADDR_W:0] hi;
  logic [3:0]      pcnt;
  logic [WCW-1:0]  wcnt;

  logic [ADDR_W-1:0] mid;
  logic [ADDR_W:0]   lo_up;
  logic [ADDR_W:0]   hi_dn;
  logic              miss_end;

  // lo + hi never exceeds 2^(ADDR_W+1)-2, so ADDR_W+1 bits hold the sum
  always_comb begin
    mid      = ADDR_W'((lo + hi) >> 1);
    lo_up    = {1'b0, search_addr} + ONE;
    hi_dn    = {1'b0, search_addr} - ONE;
    miss_end = 1'b0;
    if (greater_in) begin
      miss_end = (search_addr == MAX_ADDR) || (lo_up > hi);
    end else begin
      miss_end = (search_addr == '0) || (lo > hi_dn);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      lo          <= '0;
      hi          <= '0;
      pcnt        <= '0;
      wcnt        <= '0;
      search_addr <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hit         <= 1'b0;
      result_addr <= '0;
      probes      <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            lo          <= '0;
            hi          <= TOP;
            pcnt        <= '0;
            hit         <= 1'b0;
            result_addr <= '0;
            probes      <= '0;
            busy        <= 1'b1;
            state       <= PROBE;
          end
        end
        PROBE: begin
          search_addr <= mid;
          wcnt        <= WCW'(LAT - 1);
          state       <= WAIT;
        end
        WAIT: begin
          if (wcnt == '0) state <= EVAL;
          else            wcnt  <= wcnt - 1'b1;
        end
        EVAL: begin
          // probes/hit are loaded together with done so they are valid during the pulse
          pcnt <= pcnt + 1'b1;
          if (found_in) begin
            hit         <= 1'b1;
            result_addr <= search_addr;
            probes      <= pcnt + 1'b1;
            done        <= 1'b1;
            state       <= DONE;
          end else begin
            if (greater_in) begin
              if (search_addr != MAX_ADDR) lo <= lo_up;
            end else begin
              if (search_addr != '0) hi <= hi_dn;
            end
            if (miss_end) begin
              probes <= pcnt + 1'b1;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              state <= PROBE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bsearch_ctrl.sv
// Directed bench for bsearch_ctrl: a datapath model holding mem[i]=2i+1 answers each probe,
// table-driven searches plus hand-written start-glitch and mid-search-reset sequences.
module tb_bsearch_ctrl;
  localparam int ADDR_W = 5;
  localparam int LAT    = 2;
  localparam int PER    = LAT + 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              found_in;
  logic              greater_in;
  logic [ADDR_W-1:0] search_addr;
  logic              busy;
  logic              done;
  logic              hit;
  logic [ADDR_W-1:0] result_addr;
  logic [3:0]        probes;

  int key = 0;
  int word;
  int passed = 0;
  int total  = 0;

  bsearch_ctrl #(.ADDR_W(ADDR_W), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .found_in(found_in), .greater_in(greater_in),
    .search_addr(search_addr), .busy(busy), .done(done),
    .hit(hit), .result_addr(result_addr), .probes(probes)
  );

  always #5 clk = ~clk;

  always_comb begin
    word       = 2 * int'(search_addr) + 1;
    found_in   = (key == word);
    greater_in = (key > word);
  end

  typedef struct {
    int          key;
    logic        hit;
    int          addr;
    int          probes;
    logic [29:0] seq;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [29:0] seq6(input int a0, a1, a2, a3, a4, a5);
    return {5'(a5), 5'(a4), 5'(a3), 5'(a2), 5'(a1), 5'(a0)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic run_and_check(input vec_t v, input bit glitch);
    int e;
    bit seen;
    logic [5:0][4:0] got;
    got  = '0;
    seen = 1'b0;
    @(negedge clk);
    key   = v.key;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e = 0;
    while (!seen && e < 100) begin
      start = (glitch && (e == 2 || e == 9));
      @(posedge clk);
      e++;
      #1;
      if (e % PER == 1 && e / PER < 6) got[e / PER] = search_addr;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    check($sformatf("k%0d_done_seen", v.key), 32'(seen), 32'd1);
    if (seen) begin
      check($sformatf("k%0d_done_edge", v.key), 32'(e), 32'(v.probes * PER));
      check($sformatf("k%0d_hit", v.key), 32'(hit), 32'(v.hit));
      check($sformatf("k%0d_result_addr", v.key), 32'(result_addr), 32'(v.addr));
      check($sformatf("k%0d_probes", v.key), 32'(probes), 32'(v.probes));
      check($sformatf("k%0d_probe_seq", v.key), 32'(got), 32'(v.seq));
      check($sformatf("k%0d_busy_in_done", v.key), 32'(busy), 32'd1);
      @(posedge clk);
      #1;
      check($sformatf("k%0d_done_one_cycle", v.key), 32'(done), 32'd0);
      check($sformatf("k%0d_busy_fall", v.key), 32'(busy), 32'd0);
      check($sformatf("k%0d_hold", v.key), {hit, result_addr, probes}, {v.hit, 5'(v.addr), 4'(v.probes)});
    end
  endtask

  initial begin
    int dones;
    vec_t v33;
    vecs[0] = '{1,  1'b1, 0,  5, seq6(15, 7, 3, 1, 0, 0)};
    vecs[1] = '{63, 1'b1, 31, 6, seq6(15, 23, 27, 29, 30, 31)};
    vecs[2] = '{64, 1'b0, 0,  6, seq6(15, 23, 27, 29, 30, 31)};
    vecs[3] = '{0,  1'b0, 0,  5, seq6(15, 7, 3, 1, 0, 0)};
    vecs[4] = '{32, 1'b0, 0,  5, seq6(15, 23, 19, 17, 16, 0)};
    vecs[5] = '{31, 1'b1, 15, 1, seq6(15, 0, 0, 0, 0, 0)};
    v33     = '{33, 1'b1, 16, 5, seq6(15, 23, 19, 17, 16, 0)};

    #1;
    check("rst_search_addr", 32'(search_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_results", {hit, result_addr, probes}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) run_and_check(vecs[i], 1'b0);

    run_and_check(v33, 1'b1);

    // reset in the middle of a key-33 search
    @(negedge clk);
    key   = 33;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("pre_rst_busy", 32'(busy), 32'd1);
    check("pre_rst_addr", 32'(search_addr), 32'd23);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_outputs", {search_addr, busy, done, hit, result_addr, probes}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    check("no_done_after_abort", 32'(dones), 32'd0);
    check("idle_after_abort", 32'(busy), 32'd0);

    run_and_check(v33, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
